// File: rtl/seq_num_alloc_pkg.sv
// Shared widths for the notification payload fields that this allocator
// receives but does not use.
package seq_num_alloc_pkg;

  localparam int p_pc_bits   = 32;
  localparam int p_addr_bits = 5;
  localparam int p_data_bits = 32;

endpackage

// File: rtl/seq_num_alloc_seq_age.sv
// Age of a sequence number relative to a base pointer, modulo the window size.
module seq_age
  import seq_num_alloc_pkg::*;
#(
  parameter int p_seq_num_bits = 5
) (
  input  logic [p_seq_num_bits-1:0] base,
  input  logic [p_seq_num_bits-1:0] seq,
  output logic [p_seq_num_bits-1:0] age
);

  assign age = seq - base;

endmodule

// File: rtl/seq_num_alloc.sv
// In-order sequence number allocator with a head/tail window that is retired
// by commits and truncated by the arbitrated squash.
module seq_num_alloc
  import seq_num_alloc_pkg::*;
#(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,

  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,
  input  logic [p_pc_bits-1:0]      squash_target,

  input  logic                      commit_val,
  input  logic [p_pc_bits-1:0]      commit_pc,
  input  logic [p_addr_bits-1:0]    commit_waddr,
  input  logic [p_data_bits-1:0]    commit_wdata,
  input  logic                      commit_wen,

  output logic [p_seq_num_bits-1:0] head_seq_num,
  output logic [p_seq_num_bits:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam logic [p_seq_num_bits-1:0] c_one      = 1;
  localparam logic [p_seq_num_bits:0]   c_cnt_one  = 1;
  localparam logic [p_seq_num_bits:0]   c_full     = {1'b1, {p_seq_num_bits{1'b0}}};

  logic [p_seq_num_bits-1:0] tail_q, tail_d;
  logic [p_seq_num_bits-1:0] head_q, head_d;
  logic [p_seq_num_bits:0]   count_q, count_d;

  logic                      fire;
  logic                      do_commit;
  logic [p_seq_num_bits-1:0] sq_dist;
  logic [p_seq_num_bits:0]   sq_count;

  logic unused_notif;
  assign unused_notif = ^{squash_target, commit_pc, commit_waddr, commit_wdata, commit_wen};

  assign empty         = (count_q == '0);
  assign full          = (count_q == c_full);
  assign alloc_rdy     = !full && !squash_val;
  assign alloc_seq_num = tail_q;
  assign head_seq_num  = head_q;
  assign count         = count_q;

  assign fire      = alloc_val && alloc_rdy;
  assign do_commit = commit_val && !empty;

  // A zero distance can only mean the squash keeps the entire full window.
  assign sq_dist  = squash_seq_num + c_one - head_q;
  assign sq_count = (sq_dist == '0) ? c_full : {1'b0, sq_dist};

  always_comb begin
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    if (do_commit)
      head_d = head_q + c_one;
    if (squash_val) begin
      tail_d  = squash_seq_num + c_one;
      count_d = sq_count - {{p_seq_num_bits{1'b0}}, do_commit};
    end else begin
      if (fire)
        tail_d = tail_q + c_one;
      case ({fire, do_commit})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  logic [p_seq_num_bits-1:0] sq_age;
  logic [p_seq_num_bits-1:0] tail_age;

  seq_age #(.p_seq_num_bits(p_seq_num_bits)) u_sq_age (
    .base (head_q),
    .seq  (squash_seq_num),
    .age  (sq_age)
  );

  seq_age #(.p_seq_num_bits(p_seq_num_bits)) u_tail_age (
    .base (head_q),
    .seq  (tail_q),
    .age  (tail_age)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (commit_val)
        assert (!empty) else $error("seq_num_alloc: commit while window empty");
      if (squash_val)
        assert (!empty && ({1'b0, sq_age} < count_q))
          else $error("seq_num_alloc: squash seq_num %0d outside window", squash_seq_num);
      assert (tail_age == count_q[p_seq_num_bits-1:0])
        else $error("seq_num_alloc: tail/head/count inconsistent");
    end
  end

  function automatic string trace(int trace_level);
    if (trace_level == 0)
      return fire ? $sformatf("%2d", alloc_seq_num) : "  ";
    return $sformatf("%0d:%0d:%0d", head_q, tail_q, count_q);
  endfunction
`endif

endmodule

// File: tb/tb_seq_num_alloc.sv
// Directed scoreboard bench for seq_num_alloc with a 3-bit (8-entry) window.
module tb_seq_num_alloc;

  localparam int N   = 3;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_val = 1'b0;
  logic          alloc_rdy;
  logic [N-1:0]  alloc_seq_num;
  logic          squash_val = 1'b0;
  logic [N-1:0]  squash_seq_num = '0;
  logic [31:0]   squash_target = '0;
  logic          commit_val = 1'b0;
  logic [31:0]   commit_pc = '0;
  logic [4:0]    commit_waddr = '0;
  logic [31:0]   commit_wdata = '0;
  logic          commit_wen = 1'b0;
  logic [N-1:0]  head_seq_num;
  logic [N:0]    count;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] q_exp[$];
  logic [N-1:0] m_head = '0;
  logic [N-1:0] m_tail = '0;
  int           m_count = 0;

  seq_num_alloc #(.p_seq_num_bits(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_val      (alloc_val),
    .alloc_rdy      (alloc_rdy),
    .alloc_seq_num  (alloc_seq_num),
    .squash_val     (squash_val),
    .squash_seq_num (squash_seq_num),
    .squash_target  (squash_target),
    .commit_val     (commit_val),
    .commit_pc      (commit_pc),
    .commit_waddr   (commit_waddr),
    .commit_wdata   (commit_wdata),
    .commit_wen     (commit_wen),
    .head_seq_num   (head_seq_num),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_head  = '0;
    m_tail  = '0;
    m_count = 0;
    q_exp.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},   32'(alloc_rdy), 32'd1);
    chk({tag, "_seq"},   32'(alloc_seq_num), 32'd0);
    chk({tag, "_head"},  32'(head_seq_num), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full), 32'd0);
  endtask

  task automatic drive_idle();
    alloc_val      = 1'b0;
    commit_val     = 1'b0;
    squash_val     = 1'b0;
    squash_seq_num = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    chk_reset_vals("post_reset");
  endtask

  // One clock of stimulus: inputs at negedge, handshake sampled before posedge,
  // registered state sampled just after posedge.
  task automatic cyc(input logic a, input logic c, input logic s, input logic [N-1:0] sn);
    logic exp_rdy;
    logic do_c;
    int   d;
    @(negedge clk);
    alloc_val      = a;
    commit_val     = c;
    squash_val     = s;
    squash_seq_num = sn;
    #1;
    exp_rdy = (m_count != CAP) && !s;
    chk("alloc_rdy", 32'(alloc_rdy), 32'(exp_rdy));
    if (a && exp_rdy)
      q_exp.push_back(m_tail);
    if (alloc_val && alloc_rdy) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL grant_unexpected observed=%0d expected=none", alloc_seq_num);
      end else begin
        chk("alloc_seq_num", 32'(alloc_seq_num), 32'(q_exp.pop_front()));
      end
    end
    do_c = c && (m_count > 0);
    if (s) begin
      d = (int'(sn) + 1 + CAP - int'(m_head)) % CAP;
      if (d == 0) d = CAP;
      m_tail  = sn + 3'd1;
      m_count = d;
    end else if (a && exp_rdy) begin
      m_tail++;
      m_count++;
    end
    if (do_c) begin
      m_head++;
      m_count--;
    end
    @(posedge clk);
    #1;
    chk("head",  32'(head_seq_num), 32'(m_head));
    chk("count", 32'(count), 32'(m_count));
    chk("tail",  32'(alloc_seq_num), 32'(m_tail));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("full",  32'(full), 32'(m_count == CAP));
  endtask

  initial begin
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("init");

    // Three back-to-back grants.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_head",  32'(head_seq_num), 32'd0);

    // Fill, stall, commit while full, then wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_rdy",  32'(alloc_rdy), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("t2_full_after_commit", 32'(full), 32'd0);
    chk("t2_head_after_commit", 32'(head_seq_num), 32'd1);
    chk("t2_wrap_seq", 32'(alloc_seq_num), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // Squash with a concurrent alloc request.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 3'd2);
    chk("t3_count", 32'(count), 32'd3);
    chk("t3_next",  32'(alloc_seq_num), 32'd3);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // Squash and commit in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 3'd1);
    chk("t4_head",  32'(head_seq_num), 32'd1);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_next",  32'(alloc_seq_num), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // Squash at the youngest entry of a full window frees nothing.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 3'd7);
    chk("t5_count", 32'(count), 32'd8);
    chk("t5_full",  32'(full), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    chk("t6_count_pre", 32'(count), 32'd5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    chk_reset_vals("t6_async");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    chk_reset_vals("t6_release");
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("t6_head", 32'(head_seq_num), 32'd0);

    chk("sb_drain", 32'(q_exp.size()), 32'd0);
    drive_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
